// File: rtl/task_frame_reverser_if.sv
// Word-stream bundle for the frame reverser: i_* flows into the stage, o_* flows out.
// The slave modport is the stage itself; the master modport is its upstream/downstream peer.
interface task_frame_reverser_if #(
    parameter int TASK_WIDTH = 8
);
    logic                  i_first;
    logic                  i_last;
    logic [TASK_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic [TASK_WIDTH-1:0] o_data;
    logic                  o_last;
    logic                  o_valid;
    logic                  o_drop;
    logic                  o_busy;

    modport master (
        output i_first, i_last, i_data, i_valid,
        input  o_data, o_last, o_valid, o_drop, o_busy
    );

    modport slave (
        input  i_first, i_last, i_data, i_valid,
        output o_data, o_last, o_valid, o_drop, o_busy
    );
endinterface

// File: rtl/task_frame_reverser.sv
// Store-and-forward frame stage: captures one i_first..i_last frame, then replays it reversed
// (MODE=1) or in arrival order (MODE=0). Define TASK_REV_CHECKSUM_EN to append an XOR checksum word.
module task_frame_reverser #(
    parameter int TASK_WIDTH = 8,
    parameter int MAX_FRAME  = 64,
    parameter int MODE       = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    task_frame_reverser_if.slave bus
);
    localparam int              CW      = $clog2(MAX_FRAME) + 1;
    localparam int              AW      = $clog2(MAX_FRAME);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_FRAME);
    localparam logic [CW-1:0]   ONE     = CW'(1);
`ifdef TASK_REV_CHECKSUM_EN
    localparam logic [CW-1:0]   EXTRA_WORDS = CW'(1);
`else
    localparam logic [CW-1:0]   EXTRA_WORDS = '0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         rd_idx_q, rd_idx_d;
    logic                  trunc_q, trunc_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_last_q, rd_last_d;
    logic [TASK_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_last_q, o_last_d;
    logic                  o_drop_q, o_drop_d;
`ifdef TASK_REV_CHECKSUM_EN
    logic [TASK_WIDTH-1:0] csum_q, csum_d;
    logic                  rd_csum_q, rd_csum_d;
`endif

    logic [TASK_WIDTH-1:0] mem [MAX_FRAME];
    logic [TASK_WIDTH-1:0] rd_data_q;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [CW-1:0]         cnt_inc;
    logic [CW-1:0]         n_out;
    logic                  start_frame;

    // NOTE: every signal below gets a default before the case statement so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_idx_d    = '0;
        trunc_d     = trunc_q;
        rd_vld_d    = 1'b0;
        rd_last_d   = 1'b0;
        o_drop_d    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        start_frame = 1'b0;
        cnt_inc     = cnt_q + ONE;
        n_out       = cnt_q + EXTRA_WORDS;
`ifdef TASK_REV_CHECKSUM_EN
        csum_d      = csum_q;
        rd_csum_d   = 1'b0;
`endif

        // Output stage: one cycle behind the synchronous memory read.
        o_valid_d = rd_vld_q;
        o_last_d  = rd_vld_q & rd_last_q;
        o_data_d  = rd_vld_q ? rd_data_q : o_data_q;
`ifdef TASK_REV_CHECKSUM_EN
        if (rd_vld_q && rd_csum_q) begin
            o_data_d = csum_q;
        end
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    if (bus.i_first) begin
                        start_frame = 1'b1;
                    end else begin
                        o_drop_d = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                if (bus.i_valid) begin
                    if (bus.i_first) begin
                        // A new first word abandons the partial frame.
                        start_frame = 1'b1;
                        o_drop_d    = 1'b1;
                    end else if (trunc_q) begin
                        o_drop_d = 1'b1;
                        if (bus.i_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = AW'(cnt_q);
                        cnt_d     = cnt_inc;
                        trunc_d   = (cnt_inc == MAX_CNT);
`ifdef TASK_REV_CHECKSUM_EN
                        csum_d    = csum_q ^ bus.i_data;
`endif
                        if (bus.i_last) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                o_drop_d = bus.i_valid;
                rd_idx_d = rd_idx_q;
                if (rd_idx_q != n_out) begin
                    rd_vld_d  = 1'b1;
                    rd_idx_d  = rd_idx_q + ONE;
                    rd_last_d = (rd_idx_q == n_out - ONE);
                    if (rd_idx_q < cnt_q) begin
                        rd_en = 1'b1;
                        if (MODE != 0) begin
                            rd_addr = AW'(cnt_q - ONE - rd_idx_q);
                        end else begin
                            rd_addr = AW'(rd_idx_q);
                        end
                    end
`ifdef TASK_REV_CHECKSUM_EN
                    rd_csum_d = (rd_idx_q == cnt_q);
`endif
                end else if (!rd_vld_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            cnt_d     = ONE;
            trunc_d   = 1'b0;
`ifdef TASK_REV_CHECKSUM_EN
            csum_d    = bus.i_data;
`endif
            state_d   = bus.i_last ? ST_DRAIN : ST_FILL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            trunc_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_drop_q  <= 1'b0;
`ifdef TASK_REV_CHECKSUM_EN
            csum_q    <= '0;
            rd_csum_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            trunc_q   <= trunc_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_drop_q  <= o_drop_d;
`ifdef TASK_REV_CHECKSUM_EN
            csum_q    <= csum_d;
            rd_csum_q <= rd_csum_d;
`endif
        end
    end

    // NOTE: the frame buffer has no reset; its contents are only read after being written this frame.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.i_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_last  = o_last_q;
    assign bus.o_drop  = o_drop_q;
    assign bus.o_busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_task_frame_reverser.sv
// Scoreboard bench: two reversers (reversed MAX_FRAME=4, in-order MAX_FRAME=8) share one stimulus
// stream; a queue-based frame model predicts every output word, drop pulse and busy level.
module tb_task_frame_reverser;
    localparam int MAX_A = 4;
    localparam int MAX_B = 8;
`ifdef TASK_REV_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       last;
        int         stamp;
    } out_t;

    typedef struct {
        int k;
        int stamp;
    } drop_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    out_t  out_q[$];
    drop_t drop_q[$];

    int         ph[2];
    int         len[2];
    int         dend[2];
    logic [7:0] fbuf[2][64];
    bit         exp_busy[2];
    logic [7:0] last_dat[2];

    task_frame_reverser_if #(.TASK_WIDTH(8)) if_a ();
    task_frame_reverser_if #(.TASK_WIDTH(8)) if_b ();

    task_frame_reverser #(.TASK_WIDTH(8), .MAX_FRAME(MAX_A), .MODE(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(if_a)
    );
    task_frame_reverser #(.TASK_WIDTH(8), .MAX_FRAME(MAX_B), .MODE(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(if_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int find_out(input int k);
        for (int i = 0; i < out_q.size(); i++) if (out_q[i].k == k) return i;
        return -1;
    endfunction

    function automatic int find_drop(input int k);
        for (int i = 0; i < drop_q.size(); i++) if (drop_q[i].k == k) return i;
        return -1;
    endfunction

    // ---------------- reference model ----------------
    task automatic push_drop(input int k, input int e);
        drop_t d;
        d.k = k;
        d.stamp = e;
        drop_q.push_back(d);
    endtask

    task automatic close_frame(input int k, input int e);
        logic [7:0] x;
        int n;
        out_t o;
        x = '0;
        n = len[k];
        for (int i = 0; i < n; i++) begin
            o.k     = k;
            o.data  = (k == 0) ? fbuf[k][n-1-i] : fbuf[k][i];
            o.last  = (i == n - 1) && (CS == 0);
            o.stamp = e + 2 + i;
            out_q.push_back(o);
            x ^= fbuf[k][i];
        end
        if (CS != 0) begin
            o.k     = k;
            o.data  = x;
            o.last  = 1'b1;
            o.stamp = e + 2 + n;
            out_q.push_back(o);
        end
        dend[k] = e + n + CS + 2;
        ph[k]   = 2;
    endtask

    task automatic model_step(input int k, input int e, input logic r, input logic v,
                              input logic f, input logic l, input logic [7:0] d);
        int mx;
        mx = (k == 0) ? MAX_A : MAX_B;
        if (r) begin
            ph[k]  = 0;
            len[k] = 0;
            for (int i = out_q.size() - 1; i >= 0; i--) if (out_q[i].k == k) out_q.delete(i);
            for (int i = drop_q.size() - 1; i >= 0; i--) if (drop_q[i].k == k) drop_q.delete(i);
            exp_busy[k] = 1'b0;
            return;
        end
        case (ph[k])
            0: if (v) begin
                if (f) begin
                    fbuf[k][0] = d;
                    len[k] = 1;
                    ph[k] = 1;
                    if (l) close_frame(k, e);
                end else begin
                    push_drop(k, e);
                end
            end
            1: if (v) begin
                if (f) begin
                    push_drop(k, e);
                    fbuf[k][0] = d;
                    len[k] = 1;
                end else if (len[k] == mx) begin
                    push_drop(k, e);
                end else begin
                    fbuf[k][len[k]] = d;
                    len[k]++;
                end
                if (l) close_frame(k, e);
            end
            default: begin
                if (v) push_drop(k, e);
                if (e == dend[k]) ph[k] = 0;
            end
        endcase
        exp_busy[k] = (ph[k] != 0);
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int k, input logic v, input logic lst, input logic drp,
                       input logic bsy, input logic [7:0] dat);
        int idx;
        string p;
        p = (k == 0) ? "rev" : "fwd";
        if (rst) begin
            check($sformatf("%s_rst_valid", p), v === 1'b0, 32'(v), 32'(0));
            check($sformatf("%s_rst_data", p), dat === 8'h00, 32'(dat), 32'(0));
            check($sformatf("%s_rst_last", p), lst === 1'b0, 32'(lst), 32'(0));
            check($sformatf("%s_rst_drop", p), drp === 1'b0, 32'(drp), 32'(0));
            check($sformatf("%s_rst_busy", p), bsy === 1'b0, 32'(bsy), 32'(0));
            last_dat[k] = dat;
            return;
        end
        check($sformatf("%s_busy", p), bsy === exp_busy[k], 32'(bsy), 32'(exp_busy[k]));
        if (lst === 1'b1) check($sformatf("%s_last_needs_valid", p), v === 1'b1, 32'(v), 32'(1));

        idx = find_out(k);
        if (v === 1'b1) begin
            check($sformatf("%s_out_expected", p), idx >= 0, 32'(v), 32'(idx >= 0));
            if (idx >= 0) begin
                check($sformatf("%s_out_data", p), dat === out_q[idx].data, 32'(dat), 32'(out_q[idx].data));
                check($sformatf("%s_out_last", p), lst === out_q[idx].last, 32'(lst), 32'(out_q[idx].last));
                check($sformatf("%s_out_cycle", p), cyc == out_q[idx].stamp, 32'(cyc), 32'(out_q[idx].stamp));
                out_q.delete(idx);
            end
        end else begin
            check($sformatf("%s_hold_data", p), dat === last_dat[k], 32'(dat), 32'(last_dat[k]));
        end
        last_dat[k] = dat;
        idx = find_out(k);
        if (idx >= 0) begin
            check($sformatf("%s_out_not_overdue", p), out_q[idx].stamp > cyc, 32'(out_q[idx].stamp), 32'(cyc + 1));
            if (out_q[idx].stamp <= cyc) out_q.delete(idx);
        end

        idx = find_drop(k);
        if (drp === 1'b1) begin
            check($sformatf("%s_drop_expected", p), idx >= 0, 32'(drp), 32'(idx >= 0));
            if (idx >= 0) begin
                check($sformatf("%s_drop_cycle", p), cyc == drop_q[idx].stamp, 32'(cyc), 32'(drop_q[idx].stamp));
                drop_q.delete(idx);
            end
        end
        idx = find_drop(k);
        if (idx >= 0) begin
            check($sformatf("%s_drop_not_overdue", p), drop_q[idx].stamp > cyc, 32'(drop_q[idx].stamp), 32'(cyc + 1));
            if (drop_q[idx].stamp <= cyc) drop_q.delete(idx);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, if_a.o_valid, if_a.o_last, if_a.o_drop, if_a.o_busy, if_a.o_data);
        mon(1, if_b.o_valid, if_b.o_last, if_b.o_drop, if_b.o_busy, if_b.o_data);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic f, input logic l, input logic [7:0] d, input logic r);
        rst = r;
        if_a.i_valid = v; if_a.i_first = f; if_a.i_last = l; if_a.i_data = d;
        if_b.i_valid = v; if_b.i_first = f; if_b.i_last = l; if_b.i_data = d;
        model_step(0, cyc + 1, r, v, f, l, d);
        model_step(1, cyc + 1, r, v, f, l, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input logic f, input logic l);
        drive(1'b1, f, l, d, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(2);

        send(8'h11, 1'b1, 1'b0); send(8'h22, 1'b0, 1'b0); send(8'h33, 1'b0, 1'b1);
        idle(16);

        send(8'hA5, 1'b1, 1'b1);
        idle(16);

        for (int i = 1; i <= 6; i++) send(8'(i * 17), i == 1, i == 6);
        idle(16);

        send(8'h41, 1'b1, 1'b0); send(8'h42, 1'b0, 1'b0); send(8'h77, 1'b1, 1'b1);
        idle(16);

        send(8'h5A, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h66, 1'b0);
        idle(4);

        for (int i = 0; i < 8; i++) send(8'(8'h80 + i), i == 0, i == 7);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(3);
        send(8'h01, 1'b1, 1'b0); send(8'h02, 1'b0, 1'b1);
        idle(16);

        send(8'h0F, 1'b1, 1'b0); send(8'hF0, 1'b0, 1'b0); send(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(8'($urandom), i == 2, i == 4);
        idle(16);

        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20, 8'($urandom), $urandom_range(0, 199) == 0);
        end
        idle(30);

        check("outputs_all_seen", out_q.size() == 0, 32'(out_q.size()), 32'(0));
        check("drops_all_seen", drop_q.size() == 0, 32'(drop_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
